// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 5-stage pipeline: opcode encodings, the
// multiplier FSM state type and a helper that forms one shifted partial
// product of the iterative multiplier.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [6:0] OP_ADD  = 7'h00;
  localparam logic [6:0] OP_SUB  = 7'h01;
  localparam logic [6:0] OP_MUL  = 7'h02;
  localparam logic [6:0] OP_LDB  = 7'h10;
  localparam logic [6:0] OP_LDW  = 7'h11;
  localparam logic [6:0] OP_STB  = 7'h12;
  localparam logic [6:0] OP_STW  = 7'h13;
  localparam logic [6:0] OP_MOV  = 7'h14;
  localparam logic [6:0] OP_BEQ  = 7'h30;
  localparam logic [6:0] OP_JUMP = 7'h31;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mulState_t;

  // Partial product for byte 'idx' of operand B, already shifted into place.
  // Only the low 32 bits are kept, which is all the MUL result needs.
  function automatic logic [31:0] mulPartial(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [1:0]  idx);
    logic [4:0]  shiftAmt;
    logic [31:0] chunk;
    logic [31:0] prod;
    shiftAmt = {idx, 3'b000};
    chunk    = (b >> shiftAmt) & 32'h0000_00FF;
    prod     = a * chunk;
    return prod << shiftAmt;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ---------------------------------------------------------------------------
// execute_stage_if
// Bundles the decode-to-execute inputs (x_*), the execute-to-memory outputs
// (m_*) and the combinational stall / redirect signals of the execute stage.
// Modports:
//   slave  - the execute stage: consumes x_*, drives stall, branch_*, m_*
//   master - the surrounding pipeline: drives x_*, observes the rest
// ---------------------------------------------------------------------------
interface execute_stage_if;

  logic [6:0]  x_opcode;
  logic [5:0]  x_dst_reg;
  logic [31:0] x_pc;
  logic [14:0] x_mem_offset;
  logic [14:0] x_brn_offset;
  logic [19:0] x_jmp_offset;
  logic [31:0] x_read_data_1;
  logic [31:0] x_read_data_2;
  logic        x_mem_read;
  logic        x_mem_write;
  logic        x_mem_byte;
  logic        x_reg_write;
  logic        x_mem_to_reg;

  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;

  logic [31:0] m_alu_result;
  logic [31:0] m_store_data;
  logic [5:0]  m_dst_reg;
  logic        m_mem_read;
  logic        m_mem_write;
  logic        m_mem_byte;
  logic        m_reg_write;
  logic        m_mem_to_reg;

  modport slave (
    input  x_opcode, x_dst_reg, x_pc, x_mem_offset, x_brn_offset, x_jmp_offset,
           x_read_data_1, x_read_data_2,
           x_mem_read, x_mem_write, x_mem_byte, x_reg_write, x_mem_to_reg,
    output stall, branch_taken, branch_target,
           m_alu_result, m_store_data, m_dst_reg,
           m_mem_read, m_mem_write, m_mem_byte, m_reg_write, m_mem_to_reg
  );

  modport master (
    output x_opcode, x_dst_reg, x_pc, x_mem_offset, x_brn_offset, x_jmp_offset,
           x_read_data_1, x_read_data_2,
           x_mem_read, x_mem_write, x_mem_byte, x_reg_write, x_mem_to_reg,
    input  stall, branch_taken, branch_target,
           m_alu_result, m_store_data, m_dst_reg,
           m_mem_read, m_mem_write, m_mem_byte, m_reg_write, m_mem_to_reg
  );

endinterface

// File: rtl/execute_stage_mul_iter.sv
// ---------------------------------------------------------------------------
// mul_iter
// Iterative 32x32 -> low-32 multiplier consuming one byte of operand B per
// cycle. Starts from IDLE when i_start is seen, spends three cycles in BUSY,
// then presents the product for one DONE cycle before returning to IDLE.
// Ports:
//   clock, reset  - pipeline clock, async active-high reset
//   i_start       - a MUL is sitting in execute
//   i_opA, i_opB  - operands, held stable by upstream while stalled
//   o_busy        - FSM in BUSY
//   o_done        - FSM in DONE, o_acc holds the finished product
//   o_acc         - accumulator
// ---------------------------------------------------------------------------
module mul_iter
  import cpu_pkg::*;
#(
  parameter int MUL_ITERS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_start,
  input  logic [31:0] i_opA,
  input  logic [31:0] i_opB,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_acc
);

  localparam logic [1:0] LAST_CNT = 2'(MUL_ITERS - 1);

  mulState_t   r_state;
  mulState_t   w_nextState;
  logic [1:0]  r_cnt;
  logic [1:0]  w_nextCnt;
  logic [31:0] r_acc;
  logic [31:0] w_nextAcc;

  // State, counter and accumulator registers; reset aborts any product in
  // flight so nothing partial can ever reach the result path.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= MUL_IDLE;
      r_cnt   <= 2'd0;
      r_acc   <= 32'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_acc   <= w_nextAcc;
    end
  end

  // The first byte is folded in on the IDLE->BUSY transition, so the
  // remaining three bytes need exactly three BUSY cycles. The counter wraps
  // back to zero on the last accumulate, ready for the next MUL.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextAcc   = r_acc;
    case (r_state)
      MUL_IDLE: begin
        if (i_start) begin
          w_nextAcc   = mulPartial(i_opA, i_opB, 2'd0);
          w_nextCnt   = 2'd1;
          w_nextState = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        w_nextAcc = r_acc + mulPartial(i_opA, i_opB, r_cnt);
        w_nextCnt = r_cnt + 2'd1;
        if (r_cnt == LAST_CNT) begin
          w_nextState = MUL_DONE;
        end
      end
      MUL_DONE: begin
        w_nextState = MUL_IDLE;
      end
      default: begin
        w_nextState = MUL_IDLE;
      end
    endcase
  end

  assign o_busy = (r_state == MUL_BUSY);
  assign o_done = (r_state == MUL_DONE);
  assign o_acc  = r_acc;

endmodule

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
// Execute stage of the 5-stage pipeline. Computes ALU results, memory
// addresses and branch/jump decisions from the decode-to-execute bundle and
// registers them into the execute-to-memory bundle. MUL uses the iterative
// multiplier and holds the upstream stages while it runs.
// Ports:
//   clock, reset - pipeline clock, async active-high reset
//   bus          - execute_stage_if.slave: x_* in; stall, branch_taken,
//                  branch_target (combinational) and registered m_* out
// ---------------------------------------------------------------------------
module execute_stage
  import cpu_pkg::*;
#(
  parameter int MUL_ITERS = 4
) (
  input  logic            clock,
  input  logic            reset,
  execute_stage_if.slave  bus
);

  logic        w_isMul;
  logic        w_mulBusy;
  logic        w_mulDone;
  logic [31:0] w_mulAcc;
  logic        w_stall;
  logic [31:0] w_memAddr;
  logic [31:0] w_brnTarget;
  logic [31:0] w_jmpTarget;
  logic        w_taken;
  logic [31:0] w_result;

  logic [31:0] r_mAluResult;
  logic [31:0] r_mStoreData;
  logic [5:0]  r_mDstReg;
  logic        r_mMemRead;
  logic        r_mMemWrite;
  logic        r_mMemByte;
  logic        r_mRegWrite;
  logic        r_mMemToReg;

  assign w_isMul = (bus.x_opcode == OP_MUL);

  mul_iter #(
    .MUL_ITERS (MUL_ITERS)
  ) u_mulIter (
    .clock   (clock),
    .reset   (reset),
    .i_start (w_isMul),
    .i_opA   (bus.x_read_data_1),
    .i_opB   (bus.x_read_data_2),
    .o_busy  (w_mulBusy),
    .o_done  (w_mulDone),
    .o_acc   (w_mulAcc)
  );

  // A MUL holds the pipeline from the cycle it arrives until the multiplier
  // reaches DONE, which is the single cycle its product is captured.
  assign w_stall = w_isMul && (w_mulBusy || !w_mulDone);

  // Address and redirect arithmetic; branch/jump offsets count words.
  always_comb begin
    w_memAddr   = bus.x_read_data_1 + {{17{bus.x_mem_offset[14]}}, bus.x_mem_offset};
    w_brnTarget = bus.x_pc + ({{17{bus.x_brn_offset[14]}}, bus.x_brn_offset} << 2);
    w_jmpTarget = bus.x_pc + ({{12{bus.x_jmp_offset[19]}}, bus.x_jmp_offset} << 2);
  end

  // Redirect decision; the target is forced to zero when nothing is taken
  // so fetch never sees a stale address.
  always_comb begin
    w_taken            = 1'b0;
    bus.branch_target  = 32'd0;
    if (bus.x_opcode == OP_JUMP) begin
      w_taken           = 1'b1;
      bus.branch_target = w_jmpTarget;
    end else if ((bus.x_opcode == OP_BEQ) && (bus.x_read_data_1 == bus.x_read_data_2)) begin
      w_taken           = 1'b1;
      bus.branch_target = w_brnTarget;
    end
  end

  // Result select. Branches, jumps and unknown opcodes produce zero; their
  // control flags still travel through unchanged.
  always_comb begin
    w_result = 32'd0;
    case (bus.x_opcode)
      OP_ADD:                         w_result = bus.x_read_data_1 + bus.x_read_data_2;
      OP_SUB:                         w_result = bus.x_read_data_1 - bus.x_read_data_2;
      OP_MUL:                         w_result = w_mulAcc;
      OP_LDB, OP_LDW, OP_STB, OP_STW: w_result = w_memAddr;
      OP_MOV:                         w_result = bus.x_read_data_2;
      default:                        w_result = 32'd0;
    endcase
  end

  // Execute-to-memory register. While stalled it loads a bubble so the
  // memory stage never acts on a MUL that has not finished.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mAluResult <= 32'd0;
      r_mStoreData <= 32'd0;
      r_mDstReg    <= 6'd0;
      r_mMemRead   <= 1'b0;
      r_mMemWrite  <= 1'b0;
      r_mMemByte   <= 1'b0;
      r_mRegWrite  <= 1'b0;
      r_mMemToReg  <= 1'b0;
    end else if (w_stall) begin
      r_mAluResult <= 32'd0;
      r_mStoreData <= 32'd0;
      r_mDstReg    <= 6'd0;
      r_mMemRead   <= 1'b0;
      r_mMemWrite  <= 1'b0;
      r_mMemByte   <= 1'b0;
      r_mRegWrite  <= 1'b0;
      r_mMemToReg  <= 1'b0;
    end else begin
      r_mAluResult <= w_result;
      r_mStoreData <= bus.x_read_data_2;
      r_mDstReg    <= bus.x_dst_reg;
      r_mMemRead   <= bus.x_mem_read;
      r_mMemWrite  <= bus.x_mem_write;
      r_mMemByte   <= bus.x_mem_byte;
      r_mRegWrite  <= bus.x_reg_write;
      r_mMemToReg  <= bus.x_mem_to_reg;
    end
  end

  assign bus.stall        = w_stall;
  assign bus.branch_taken = w_taken;
  assign bus.m_alu_result = r_mAluResult;
  assign bus.m_store_data = r_mStoreData;
  assign bus.m_dst_reg    = r_mDstReg;
  assign bus.m_mem_read   = r_mMemRead;
  assign bus.m_mem_write  = r_mMemWrite;
  assign bus.m_mem_byte   = r_mMemByte;
  assign bus.m_reg_write  = r_mRegWrite;
  assign bus.m_mem_to_reg = r_mMemToReg;

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage pipeline: consumes the registered decode-to-execute bundle (`x_*`) and computes ALU results, memory addresses and branch/jump decisions. MUL runs in a 4-iteration multiplier and stalls upstream stages while it runs. Results are registered into the execute-to-memory bundle (`m_*`) that drives the memory stage.

## Interface
Parameters:
- `MUL_ITERS`, 4: multiplier iterations (8-bit chunk of operand B per iteration); only 4 is supported.

Ports (one clock; reset is asynchronous and active-high):
- `clock`  in  1  pipeline clock.
- `reset`  in  1  asynchronous, active-high; clears all state and `m_*` outputs.
- `x_opcode`  in  7  operation code.
- `x_dst_reg`  in  6  destination register index.
- `x_pc`  in  32  PC of the instruction in execute.
- `x_mem_offset`  in  15  M-type offset, sign-extended.
- `x_brn_offset`  in  15  B-type word offset, sign-extended.
- `x_jmp_offset`  in  20  jump word offset, sign-extended.
- `x_read_data_1`, `x_read_data_2`  in  32 each  operands A, B.
- `x_mem_read`, `x_mem_write`, `x_mem_byte`, `x_reg_write`, `x_mem_to_reg`  in  1 each  control flags.
- `stall`  out  1  combinational; holds PC, F/D and D/X registers.
- `branch_taken`  out  1  combinational; redirects fetch and flushes F/D and D/X.
- `branch_target`  out  32  combinational redirect address.
- `m_alu_result`  out  32  registered ALU result or memory address.
- `m_store_data`  out  32  registered operand B.
- `m_dst_reg`  out  6  registered.
- `m_mem_read`, `m_mem_write`, `m_mem_byte`, `m_reg_write`, `m_mem_to_reg`  out  1 each  registered flags.

## Operation
- Opcodes: ADD 7'h00, SUB 7'h01, MUL 7'h02, LDB 7'h10, LDW 7'h11, STB 7'h12, STW 7'h13, MOV 7'h14, BEQ 7'h30, JUMP 7'h31. Any other opcode is a NOP: result 0, control flags passed through unchanged.
- ADD: A+B. SUB: A−B. MOV: B. All arithmetic is 32-bit modulo; no flags, no traps.
- Loads and stores: result = A + sext32(mem_offset); `m_store_data` = B.
- BEQ: taken when A==B; target = x_pc + (sext32(brn_offset)<<2).
- JUMP: always taken; target = x_pc + (sext32(jmp_offset)<<2).
- `branch_target` = 0 when `branch_taken` = 0.
- MUL: low 32 bits of A*B, unsigned (identical to signed in the low word).
- MUL FSM, IDLE/BUSY with 2-bit counter `cnt` and 32-bit accumulator `acc`:
  - IDLE with opcode MUL: `acc` ← A*B[7:0], `cnt` ← 1, go to BUSY.
  - BUSY: `acc` ← `acc` + (A*B[8·cnt+7:8·cnt] << 8·cnt), `cnt`+1.
  - BUSY with `cnt`=3: after that accumulate, go to DONE.
  - DONE: one cycle; result = `acc`; return to IDLE.
- `stall` = (opcode==MUL) && state≠DONE.
- While `stall`=1, the `m_*` register loads a bubble: all flags 0, data 0, dst 0.
- No forwarding or hazard detection here; operands arrive already resolved.

## Timing
- Reset: all `m_*` 0, FSM IDLE, `cnt` 0, `acc` 0. Reset mid-MUL aborts; no partial result is written.
- Non-MUL: 1-cycle latency. An instruction in X during cycle T appears on `m_*` in T+1.
- MUL in X at cycle T: `stall` high in T, T+1, T+2, T+3; low in T+4. Result on `m_*` in T+5, bubbles in T+1..T+4.
- Back-to-back MUL: the second enters X in T+5 from IDLE, giving the same 4-cycle stall pattern.
- `branch_taken` and `branch_target` are valid in the same cycle as the branch sits in X. The branch itself is written to `m_*` as a NOP; its flags are 0 from decode.
- Operands must stay stable while `stall`=1; upstream guarantees this.

## Structure
- Shared package `cpu_pkg`: opcode localparams and the MUL FSM state enum. Decode and the other stages use the same package.
- One sub-module, `mul_iter`: the FSM, `cnt` and `acc`. Outputs `busy` and `done`; `stall` is derived from these.
- Combinational ALU and branch logic plus the `m_*` register live in `execute_stage`.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle -> all `m_*` 0 immediately, `stall` 0.
- ADD 0xFFFFFFFF+1 -> `m_alu_result` 0 next cycle. SUB 5−7 -> 0xFFFFFFFE. STW A=0x100, offset 15'h7FFC (−4) -> address 0xFC, `m_store_data` = B, `m_mem_write` 1.
- MUL 0x12345678*0x9ABCDEF0 -> `stall` high exactly 4 cycles, then `m_alu_result` 0x242D2080 with `m_reg_write` 1; bubbles on `m_*` during the stall.
- MUL interrupted by `reset` at cycle T+2 -> `stall` drops, FSM IDLE, no write. A following ADD completes in 1 cycle.
- BEQ, pc 0x40, A=B=9, brn_offset −2 -> `branch_taken` 1, target 0x38. With A≠B -> taken 0, target 0.
- JUMP, pc 0x1000, jmp_offset 0x00010 -> target 0x1040, taken 1. Followed by MUL, MUL back-to-back -> two 4-cycle stalls and correct products.
